// File: rtl/adder_acc_pkg.sv
// Shared definitions for the adder_acc_32bit accumulation stage.
//   acc_state_t : control FSM encoding (IDLE, ACCUM, HOLD)
//   ACC_W       : accumulator / operand width
//   ACC_MAX     : saturation value used when ACC_SATURATE_EN is defined
package adder_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  localparam int              ACC_W   = 32;
  localparam logic [ACC_W-1:0] ACC_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/adder_32bit.sv
// Combinational 32-bit unsigned adder.
// Ports:
//   A, B : 32-bit operands
//   S    : 32-bit sum (modulo 2^32)
//   C32  : carry out of bit 31
module adder_32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] S,
  output logic        C32
);

  assign {C32, S} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/adder_acc_32bit.sv
// Burst accumulator built around one adder_32bit instance.
// A burst of len operands is summed into a running register (acc feeds A,
// the incoming operand feeds B); the final sum and a sticky carry flag are
// returned through an output handshake.
//
// Optional feature: define ACC_SATURATE_EN to clamp acc at 32'hFFFF_FFFF on
// carry instead of wrapping. Default build wraps modulo 2^32.
//
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   start, len    : begin a burst of len operands (sampled only in IDLE)
//   in_valid/in_ready/in_data   : operand stream
//   out_valid/out_ready/out_sum/out_ovf : result stream
//   busy          : high whenever the FSM is not in IDLE
//   state_dbg     : current FSM state, for observation only
//
// Handshake semantics (both streams): a transfer happens on a rising edge
// where valid and ready are both high. in_ready and out_valid depend only on
// registered state, so neither has a combinational path from any input; the
// result stays stable while out_valid is high until it is taken.
module adder_acc_32bit
  import adder_acc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [ACC_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy,
  output acc_state_t       state_dbg
);

  acc_state_t       state, state_n;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] remaining;

  logic [ACC_W-1:0] add_s;
  logic             add_c32;
  logic [ACC_W-1:0] acc_next;
  logic             beat;
  logic             launch;

  adder_32bit u_adder (
    .A   (acc),
    .B   (in_data),
    .S   (add_s),
    .C32 (add_c32)
  );

`ifdef ACC_SATURATE_EN
  // Once clamped, acc + nonzero carries again and acc + 0 stays at max,
  // so the register holds ACC_MAX for the rest of the burst.
  assign acc_next = add_c32 ? ACC_MAX : add_s;
`else
  assign acc_next = add_s;
`endif

  assign beat   = (state == ACCUM) && in_valid;
  assign launch = (state == IDLE) && start;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = (len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid && (remaining == CNT_W'(1))) begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath registers change only at burst launch or on an accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else if (launch) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= len;
    end else if (beat) begin
      acc       <= acc_next;
      ovf       <= ovf | add_c32;
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign state_dbg = state;

endmodule

// File: tb/tb_adder_acc_32bit.sv
// Directed testbench for adder_acc_32bit. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_adder_acc_32bit;
  import adder_acc_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_sum;
  logic             out_ovf;
  logic             busy;
  acc_state_t       state_dbg;

  int checks = 0;
  int failures = 0;

  adder_acc_32bit #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [CNT_W-1:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    len   = n;
    @(posedge clk); #1;
    start = 1'b0;
    len   = '0;
  endtask

  // Presents one operand after 'gaps' idle cycles and holds it until taken.
  task automatic send_beat(input logic [31:0] d, input int gaps);
    int guard;
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      failures++;
      $display("FAIL beat_accept: in_ready=%0b required=1 (timeout)", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Leaves the caller at a falling edge with out_valid high, or logs a timeout.
  task automatic wait_out_valid();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      failures++;
      $display("FAIL out_valid_wait: out_valid=%0b required=1 (timeout)", out_valid);
    end
  endtask

  task automatic take_result();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    // after power-on reset
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_ovf, busy} !== 4'b0 || out_sum !== 32'd0) begin
      failures++;
      $display("FAIL reset_por: rdy=%0b vld=%0b ovf=%0b busy=%0b sum=%h required all 0",
               in_ready, out_valid, out_ovf, busy, out_sum);
    end
    // reset asserted mid-cycle during a partial burst
    do_start(8'd3);
    send_beat(32'd5, 0);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_ctl: rdy=%0b vld=%0b busy=%0b required 0 0 0",
               in_ready, out_valid, busy);
    end
    checks++;
    if (out_sum !== 32'd0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_data: sum=%h ovf=%0b required 00000000 0", out_sum, out_ovf);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      failures++;
      $display("FAIL reset_state: state=%0d required=%0d", state_dbg, IDLE);
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_basic();
    do_start(8'd3);
    send_beat(32'd5, 0);
    send_beat(32'd7, 0);
    send_beat(32'd9, 0);
    // keep offering data: none of it may be taken
    in_valid = 1'b1;
    in_data  = 32'd100;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_timing: out_valid=%0b in_ready=%0b required 1 0", out_valid, in_ready);
    end
    checks++;
    if (out_sum !== 32'd21 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL basic_sum: sum=%0d ovf=%0b required 21 0", out_sum, out_ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (out_sum !== 32'd21) begin
      failures++;
      $display("FAIL basic_no_extra: sum=%0d required 21", out_sum);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_release: out_valid=%0b busy=%0b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_sum;
`ifdef ACC_SATURATE_EN
    exp_sum = 32'hFFFF_FFFF;
`else
    exp_sum = 32'h0000_0010;
`endif
    do_start(8'd2);
    send_beat(32'hFFFF_FFF0, 0);
    send_beat(32'h0000_0020, 0);
    wait_out_valid();
    checks++;
    if (out_sum !== exp_sum || out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL overflow: sum=%h ovf=%0b required %h 1", out_sum, out_ovf, exp_sum);
    end
    take_result();
  endtask

  task automatic test_stall_backpressure();
    logic [31:0] beats [4];
    beats[0] = 32'd10;
    beats[1] = 32'd20;
    beats[2] = 32'd30;
    beats[3] = 32'd40;
    do_start(8'd4);
    for (int i = 0; i < 4; i++) begin
      send_beat(beats[i], $urandom_range(0, 3));
      if (i == 1) begin
        // start during ACCUM must not restart the burst
        start = 1'b1;
        len   = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        len   = '0;
      end
    end
    wait_out_valid();
    checks++;
    if (out_sum !== 32'd100 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL stall_sum: sum=%0d ovf=%0b required 100 0", out_sum, out_ovf);
    end
    start = 1'b1;
    len   = 8'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 32'd100) begin
        failures++;
        $display("FAIL hold_stable: cycle=%0d out_valid=%0b sum=%0d required 1 100",
                 c, out_valid, out_sum);
      end
    end
    start = 1'b0;
    len   = '0;
    take_result();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || state_dbg !== IDLE) begin
      failures++;
      $display("FAIL stall_idle: busy=%0b state=%0d required 0 %0d", busy, state_dbg, IDLE);
    end
  endtask

  task automatic test_zero_len();
    in_valid = 1'b1;
    in_data  = 32'd55;
    do_start(8'd0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_timing: out_valid=%0b in_ready=%0b required 1 0", out_valid, in_ready);
    end
    checks++;
    if (out_sum !== 32'd0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL zero_result: sum=%h ovf=%0b required 00000000 0", out_sum, out_ovf);
    end
    in_valid = 1'b0;
    take_result();
  endtask

  task automatic test_abort_restart();
    do_start(8'd4);
    send_beat(32'd3, 0);
    send_beat(32'd4, 0);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== 32'd0) begin
      failures++;
      $display("FAIL abort: busy=%0b out_valid=%0b sum=%0d required 0 0 0",
               busy, out_valid, out_sum);
    end
    do_start(8'd2);
    send_beat(32'd1, 0);
    send_beat(32'd1, 1);
    wait_out_valid();
    checks++;
    if (out_sum !== 32'd2 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL restart_sum: sum=%0d ovf=%0b required 2 0", out_sum, out_ovf);
    end
    take_result();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    #23 rst = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_stall_backpressure();
    test_zero_len();
    test_abort_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, required completion");
    $fatal(1);
  end

endmodule

// File: doc/adder_acc_32bit.md
# adder_acc_32bit

Sequential accumulation stage placed directly downstream of the combinational `adder_32bit`. It consumes the adder's `S` and `C32` outputs. A burst of `len` 32-bit operands arrives over a valid/ready stream. Each accepted operand is added to a running register by routing the register into `A` and the operand into `B` of one `adder_32bit` instance. The block returns the final sum and an overflow flag through an output valid/ready handshake.

## Interface
- `CNT_W`, default 8: width of burst-length field; maximum burst is 2^CNT_W − 1 operands.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: begin a burst; sampled only in IDLE.
- `len` in CNT_W: operand count, sampled with `start`.
- `in_valid` in 1: operand valid.
- `in_data` in 32: operand.
- `in_ready` out 1: operand accepted when `in_valid` and `in_ready` are both high.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid` and `out_ready` are both high.
- `out_sum` out 32: accumulated sum.
- `out_ovf` out 1: at least one add produced `C32` = 1 during the burst.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: `in_ready` = 0, `out_valid` = 0.
    - `start` with `len` ≠ 0: clear acc and ovf, load remaining = `len`, go to ACCUM.
    - `start` with `len` = 0: clear acc and ovf, go directly to HOLD (sum 0, ovf 0).
  - ACCUM: `in_ready` = 1.
    - On each accepted beat: acc ← `S` of (acc + `in_data`), ovf ← ovf | `C32`, remaining ← remaining − 1.
    - When the beat is accepted with remaining = 1: go to HOLD.
  - HOLD: `out_valid` = 1; `out_sum` and `out_ovf` are held stable.
    - On handshake: go to IDLE.
- `start` is ignored outside IDLE.
- `in_valid` is ignored outside ACCUM; no beat is consumed.
- Arithmetic is unsigned 32-bit. Without saturation the sum wraps modulo 2^32.
- The register is updated only on an accepted beat. An idle cycle (`in_valid` low) changes nothing.
- Reset mid-burst aborts the burst with no output. Reset values:
  - state = IDLE
  - acc = 0
  - remaining = 0
  - `in_ready` = 0, `out_valid` = 0, `out_sum` = 0, `out_ovf` = 0, `busy` = 0

## Timing
- `in_ready`, `out_valid` and `busy` are decoded from the registered state only. There is no combinational path from any input to these outputs.
- Throughput is one operand per cycle while `in_valid` stays high.
- `start` at edge T with `len` = N and `in_valid` continuously high:
  - first beat accepted at edge T+1;
  - last beat accepted at edge T+N;
  - `out_valid` high in the cycle after edge T+N.
- `start` with `len` = 0 at edge T: `out_valid` high in the cycle after edge T.
- If `out_ready` is already high when `out_valid` rises, the result is consumed at the next edge. The block is back in IDLE one cycle after that handshake, so the earliest next `start` is sampled at the following edge.
- The adder path (acc → `adder_32bit` → acc) is the single register-to-register critical path.

## Configuration
- `ACC_SATURATE_EN` defined:
  - when an accepted beat produces `C32` = 1, acc ← 32'hFFFF_FFFF instead of `S`;
  - ovf is still set;
  - once saturated, acc stays at 32'hFFFF_FFFF for the rest of the burst.
- `ACC_SATURATE_EN` undefined: acc wraps to `S`, and `out_ovf` is a sticky carry flag.

## Structure
- Shared package `adder_acc_pkg`:
  - state enum `acc_state_t` (IDLE, ACCUM, HOLD);
  - constant `ACC_W` = 32;
  - constant `ACC_MAX` = 32'hFFFF_FFFF.
- Exactly one sub-module: the existing `adder_32bit`, instantiated unchanged with `A` = acc, `B` = `in_data`.
- All sequential logic lives in `adder_acc_32bit`.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle → all outputs are 0 immediately and the state is IDLE.
- Basic burst: `start`, `len` = 3, beats 5, 7, 9 back-to-back → `out_sum` = 21, `out_ovf` = 0, `out_valid` high in the cycle after the third accepted beat; no beat is accepted after the third.
- Overflow burst: `len` = 2, beats 0xFFFF_FFF0 and 0x20.
  - Macro undefined → `out_sum` = 0x10, `out_ovf` = 1.
  - `ACC_SATURATE_EN` defined → `out_sum` = 0xFFFF_FFFF, `out_ovf` = 1.
- Stall and backpressure: `len` = 4 with `in_valid` deasserted randomly, and `out_ready` held low for 5 cycles.
  - Sum is correct.
  - `out_sum` is stable while `out_valid` is high and `out_ready` is low.
  - `start` pulses during the burst are ignored.
- Zero-length burst: `start` with `len` = 0 → `out_valid` high in the cycle after the `start` edge, `out_sum` = 0, `out_ovf` = 0, no operand accepted.
- Abort and restart: assert `rst` after 2 of 4 beats, then run a fresh burst of 1, 1 → `out_sum` = 2; no stale partial sum appears.
